tx_byte_sched: RTL and testbench
================================

TX_BYTE_SCHED -- requirements
Module: tx_byte_sched

Interface
REQ-001 SHALL have parameter BUSY_TO, default 255, meaning the number of cycles to wait for Busy to rise after a byte is issued before re-issuing it (legal range 2..255).
REQ-002 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port OUT_Valid  input  1  one-cycle pulse; ALU_OUT holds a valid result.
REQ-005 SHALL have port ALU_OUT  input  16  ALU result.
REQ-006 SHALL have port RdData_Valid  input  1  one-cycle pulse; RdData holds valid register-file read data.
REQ-007 SHALL have port RdData  input  8  register-file read data.
REQ-008 SHALL have port Busy  input  1  UART TX busy, already synchronised to CLK.
REQ-009 SHALL have port OVF_CLR  input  1  clears the OVF flag.
REQ-010 SHALL have port TX_P_DATA  output  8  byte presented to UART TX.
REQ-011 SHALL have port TX_D_Valid  output  1  one-cycle byte-issue strobe.
REQ-012 SHALL have port Sched_Busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 SHALL have port OVF  output  1  sticky flag: a request was dropped.

Function
REQ-014 SHALL hold one pending slot per source: ALU (16 bit) and RD (8 bit), each with a pending flag.
- A valid pulse loads the slot data and sets its flag.
REQ-015 A valid pulse arriving while that slot's flag is already set SHALL discard the new data, keep the old data, and set OVF.
REQ-016 On grant the slot data SHALL move into the frame buffer and the flag SHALL clear.
- A valid pulse in the grant cycle SHALL be captured as a new request, with no overflow.
REQ-017 The FSM SHALL have states IDLE, SEND, WAIT_H and WAIT_L.
REQ-018 IDLE: if any flag is set, grant one source per REQ-026, load the frame buffer, go to SEND. Otherwise stay in IDLE.
REQ-019 SEND: while Busy=1, stay.
- When Busy=0, drive TX_P_DATA with the current byte, pulse TX_D_Valid for exactly one cycle, clear the timeout counter, go to WAIT_H.
REQ-020 WAIT_H: Busy=1 goes to WAIT_L.
- If the counter reaches BUSY_TO first, go to SEND and re-issue the same byte.
REQ-021 WAIT_L: Busy=0 goes to SEND with the next byte if bytes remain in the frame; otherwise go to IDLE.
REQ-022 ALU frames SHALL be sent as two bytes, ALU_OUT[7:0] first and then ALU_OUT[15:8]. RD frames SHALL be one byte.
REQ-023 TX_P_DATA SHALL be registered and SHALL hold its value between strobes.
REQ-024 Minimum latency from a valid pulse (source idle, Busy=0) to TX_D_Valid SHALL be 3 cycles: capture, IDLE grant, SEND issue.
REQ-025 OVF SHALL be set by REQ-015 and cleared by OVF_CLR. If set and clear occur in the same cycle, set SHALL win.

Reset
REQ-026 Arbitration: with ARB_RR_EN defined, alternate the sources when both are pending. The last-grant bit resets to RD, so the ALU wins the first tie.
REQ-027 While RST=0: state=IDLE, both flags=0, slot data=0, counter=0, TX_P_DATA=0x00, TX_D_Valid=0, Sched_Busy=0, OVF=0.
REQ-028 Reset mid-frame SHALL abort the frame immediately. No further TX_D_Valid SHALL be issued until a new valid pulse arrives after RST deasserts.

Configuration
REQ-029 Macro ARB_RR_EN defined: round-robin arbitration between ALU and RD, with the last-grant register updated on every grant.
REQ-030 Macro ARB_RR_EN undefined: fixed priority, ALU over RD. There SHALL be no last-grant register.

Verification
REQ-031 Single ALU result: OUT_Valid with ALU_OUT=0xA55A, Busy toggling correctly -> bytes 0x5A then 0xA5, two TX_D_Valid pulses, first pulse 3 cycles after OUT_Valid.
REQ-032 Simultaneous requests: OUT_Valid (0x1234) and RdData_Valid (0x7E) in the same cycle, ARB_RR_EN defined -> bytes 0x34, 0x12, 0x7E.
- A second simultaneous pair SHALL then send 0x7E-source data first.
REQ-033 Overflow: two RdData_Valid pulses (0x11, 0x22) while Busy is held high -> only 0x11 is sent and OVF=1. OVF_CLR -> OVF=0.
REQ-034 Busy never rises, BUSY_TO=4: first byte 0x5A issued -> TX_D_Valid re-issued with 0x5A 5 cycles later, repeating until Busy rises.
REQ-035 Reset mid-frame: RST low after the first byte of 0xBEEF -> outputs return to reset values, and no 0xBE byte is issued after RST releases.

Source files
------------

// File: rtl/tx_byte_sched.sv
// Byte scheduler: buffers ALU and register-file results and feeds them byte-wise to a UART transmitter.
// Define ARB_RR_EN for round-robin arbitration; otherwise the ALU always has priority over RD.
module tx_byte_sched #(
  parameter int unsigned BUSY_TO = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        OUT_Valid,
  input  logic [15:0] ALU_OUT,
  input  logic        RdData_Valid,
  input  logic [7:0]  RdData,
  input  logic        Busy,
  input  logic        OVF_CLR,
  output logic [7:0]  TX_P_DATA,
  output logic        TX_D_Valid,
  output logic        Sched_Busy,
  output logic        OVF
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_H, WAIT_L} state_t;

  localparam logic [7:0] TO_LAST = 8'(BUSY_TO - 1);

  state_t      state, state_nxt;
  logic        alu_pend, rd_pend;
  logic [15:0] alu_data;
  logic [7:0]  rd_data;
  logic [15:0] fbuf;
  logic        two_byte, byte_hi;
  logic [7:0]  cnt;
  logic        grant_alu, grant_rd;
  logic        issue, more, ovf_set;
  logic [7:0]  cur_byte;

`ifdef ARB_RR_EN
  logic last_alu;

  // On a tie the source that did not win last time gets the grant.
  assign grant_alu = (state == IDLE) && alu_pend && (!rd_pend || !last_alu);
  assign grant_rd  = (state == IDLE) && rd_pend && !grant_alu;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      last_alu <= 1'b0;
    else if (grant_alu || grant_rd)
      last_alu <= grant_alu;
  end
`else
  assign grant_alu = (state == IDLE) && alu_pend;
  assign grant_rd  = (state == IDLE) && rd_pend && !alu_pend;
`endif

  assign issue      = (state == SEND) && !Busy;
  assign more       = two_byte && !byte_hi;
  assign cur_byte   = byte_hi ? fbuf[15:8] : fbuf[7:0];
  assign Sched_Busy = (state != IDLE);
  assign ovf_set    = (OUT_Valid && alu_pend && !grant_alu) ||
                      (RdData_Valid && rd_pend && !grant_rd);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_alu || grant_rd) state_nxt = SEND;
      SEND:    if (!Busy) state_nxt = WAIT_H;
      WAIT_H:  if (Busy) state_nxt = WAIT_L;
               else if (cnt == TO_LAST) state_nxt = SEND;
      WAIT_L:  if (!Busy) state_nxt = more ? SEND : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Pending slots: a pulse in the grant cycle refills the slot that is being emptied.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      alu_pend <= 1'b0;
      alu_data <= '0;
      rd_pend  <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (OUT_Valid && (!alu_pend || grant_alu)) begin
        alu_pend <= 1'b1;
        alu_data <= ALU_OUT;
      end else if (grant_alu) begin
        alu_pend <= 1'b0;
      end
      if (RdData_Valid && (!rd_pend || grant_rd)) begin
        rd_pend <= 1'b1;
        rd_data <= RdData;
      end else if (grant_rd) begin
        rd_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fbuf     <= '0;
      two_byte <= 1'b0;
      byte_hi  <= 1'b0;
    end else if (grant_alu) begin
      fbuf     <= alu_data;
      two_byte <= 1'b1;
      byte_hi  <= 1'b0;
    end else if (grant_rd) begin
      fbuf     <= {8'h00, rd_data};
      two_byte <= 1'b0;
      byte_hi  <= 1'b0;
    end else if ((state == WAIT_L) && !Busy && more) begin
      byte_hi  <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      TX_P_DATA  <= 8'h00;
      TX_D_Valid <= 1'b0;
      cnt        <= '0;
    end else begin
      TX_D_Valid <= issue;
      if (issue) begin
        TX_P_DATA <= cur_byte;
        cnt       <= '0;
      end else if ((state == WAIT_H) && !Busy) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // Set has priority over clear so a drop in the clear cycle is never lost.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      OVF <= 1'b0;
    else if (ovf_set)
      OVF <= 1'b1;
    else if (OVF_CLR)
      OVF <= 1'b0;
  end

endmodule

// File: tb/tb_tx_byte_sched.sv
// Directed bench for tx_byte_sched with a simple UART Busy responder and an issued-byte log.
module tb_tx_byte_sched;

  logic        CLK = 1'b0;
  logic        RST;
  logic        OUT_Valid;
  logic [15:0] ALU_OUT;
  logic        RdData_Valid;
  logic [7:0]  RdData;
  logic        Busy = 1'b0;
  logic        OVF_CLR;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_Valid;
  logic        Sched_Busy;
  logic        OVF;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          bcnt = 0;
  int          busy_mode = 0;  // 0: responds to strobes, 1: held high, 2: held low
  logic [7:0]  bytes_q[$];
  int          stamp_q[$];
  logic [7:0]  exp_rr[5];
  int          t0;

  tx_byte_sched #(.BUSY_TO(4)) dut (
    .CLK(CLK), .RST(RST), .OUT_Valid(OUT_Valid), .ALU_OUT(ALU_OUT),
    .RdData_Valid(RdData_Valid), .RdData(RdData), .Busy(Busy), .OVF_CLR(OVF_CLR),
    .TX_P_DATA(TX_P_DATA), .TX_D_Valid(TX_D_Valid), .Sched_Busy(Sched_Busy), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  // Log issued bytes and model the UART: Busy high for three cycles after each strobe.
  always @(posedge CLK) begin
    #1;
    cyc++;
    if (TX_D_Valid) begin
      bytes_q.push_back(TX_P_DATA);
      stamp_q.push_back(cyc);
    end
    case (busy_mode)
      1: begin Busy = 1'b1; bcnt = 0; end
      2: begin Busy = 1'b0; bcnt = 0; end
      default: begin
        if (TX_D_Valid) begin
          Busy = 1'b1; bcnt = 3;
        end else if (bcnt > 0) begin
          bcnt--; Busy = (bcnt != 0);
        end else begin
          Busy = 1'b0;
        end
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic pulse_alu(input logic [15:0] v);
    OUT_Valid = 1'b1; ALU_OUT = v;
    wait_cycles(1);
    OUT_Valid = 1'b0;
  endtask

  task automatic pulse_rd(input logic [7:0] v);
    RdData_Valid = 1'b1; RdData = v;
    wait_cycles(1);
    RdData_Valid = 1'b0;
  endtask

  task automatic pulse_both(input logic [15:0] a, input logic [7:0] r);
    OUT_Valid = 1'b1; ALU_OUT = a; RdData_Valid = 1'b1; RdData = r;
    wait_cycles(1);
    OUT_Valid = 1'b0; RdData_Valid = 1'b0;
  endtask

  initial begin
`ifdef ARB_RR_EN
    exp_rr = '{8'h34, 8'h12, 8'h7E, 8'h78, 8'h56};
`else
    exp_rr = '{8'h34, 8'h12, 8'h78, 8'h56, 8'h7E};
`endif
    RST = 1'b0; OUT_Valid = 1'b0; ALU_OUT = '0; RdData_Valid = 1'b0; RdData = '0; OVF_CLR = 1'b0;
    wait_cycles(3);
    check("rst_data", 32'(TX_P_DATA), 32'h00);
    check("rst_valid", 32'(TX_D_Valid), 32'h0);
    check("rst_sched_busy", 32'(Sched_Busy), 32'h0);
    check("rst_ovf", 32'(OVF), 32'h0);
    RST = 1'b1;
    wait_cycles(2);

    // Single ALU result
    t0 = cyc;
    pulse_alu(16'hA55A);
    wait_cycles(40);
    check("alu_count", 32'(bytes_q.size()), 32'd2);
    if (bytes_q.size() == 2) begin
      check("alu_byte0", 32'(bytes_q[0]), 32'h5A);
      check("alu_byte1", 32'(bytes_q[1]), 32'hA5);
      check("alu_latency", 32'(stamp_q[0] - t0), 32'd3);
    end
    check("alu_idle", 32'(Sched_Busy), 32'h0);

    // Simultaneous pair, then a second pair while the first ALU frame is in flight
    bytes_q.delete(); stamp_q.delete();
    pulse_both(16'h1234, 8'h7E);
    wait_cycles(1);
    pulse_both(16'h5678, 8'h55);
    check("pair_ovf", 32'(OVF), 32'h1);
    wait_cycles(80);
    check("pair_count", 32'(bytes_q.size()), 32'd5);
    if (bytes_q.size() == 5)
      for (int i = 0; i < 5; i++)
        check($sformatf("pair_byte%0d", i), 32'(bytes_q[i]), 32'(exp_rr[i]));
    OVF_CLR = 1'b1;
    wait_cycles(1);
    OVF_CLR = 1'b0;
    check("pair_ovf_clr", 32'(OVF), 32'h0);

    // Overflow on the RD slot while the UART stays busy; set beats a simultaneous clear
    bytes_q.delete(); stamp_q.delete();
    busy_mode = 1;
    wait_cycles(2);
    pulse_alu(16'hC0DE);
    wait_cycles(3);
    pulse_rd(8'h11);
    check("ovf_before", 32'(OVF), 32'h0);
    wait_cycles(2);
    OVF_CLR = 1'b1;
    pulse_rd(8'h22);
    OVF_CLR = 1'b0;
    check("ovf_set_wins", 32'(OVF), 32'h1);
    check("ovf_held_no_issue", 32'(bytes_q.size()), 32'd0);
    busy_mode = 0;
    wait_cycles(60);
    check("ovf_count", 32'(bytes_q.size()), 32'd3);
    if (bytes_q.size() == 3) begin
      check("ovf_byte0", 32'(bytes_q[0]), 32'hDE);
      check("ovf_byte1", 32'(bytes_q[1]), 32'hC0);
      check("ovf_byte2", 32'(bytes_q[2]), 32'h11);
    end
    check("ovf_sticky", 32'(OVF), 32'h1);
    OVF_CLR = 1'b1;
    wait_cycles(1);
    OVF_CLR = 1'b0;
    check("ovf_cleared", 32'(OVF), 32'h0);

    // Busy never rises: the first byte is re-issued every five cycles
    bytes_q.delete(); stamp_q.delete();
    busy_mode = 2;
    wait_cycles(2);
    pulse_alu(16'hA55A);
    for (int i = 0; i < 40 && bytes_q.size() < 3; i++) wait_cycles(1);
    busy_mode = 0;
    check("to_reached", 32'(bytes_q.size() >= 3), 32'h1);
    wait_cycles(40);
    check("to_count", 32'(bytes_q.size()), 32'd5);
    if (bytes_q.size() == 5) begin
      for (int i = 0; i < 4; i++)
        check($sformatf("to_byte%0d", i), 32'(bytes_q[i]), 32'h5A);
      check("to_byte4", 32'(bytes_q[4]), 32'hA5);
      check("to_gap1", 32'(stamp_q[1] - stamp_q[0]), 32'd5);
      check("to_gap2", 32'(stamp_q[2] - stamp_q[1]), 32'd5);
    end

    // Reset right after the first byte of a frame
    bytes_q.delete(); stamp_q.delete();
    pulse_alu(16'hBEEF);
    for (int i = 0; i < 20 && bytes_q.size() < 1; i++) wait_cycles(1);
    check("mid_first", 32'(bytes_q.size()), 32'd1);
    RST = 1'b0;
    #1;
    check("mid_rst_data", 32'(TX_P_DATA), 32'h00);
    check("mid_rst_valid", 32'(TX_D_Valid), 32'h0);
    check("mid_rst_sched_busy", 32'(Sched_Busy), 32'h0);
    check("mid_rst_ovf", 32'(OVF), 32'h0);
    wait_cycles(3);
    RST = 1'b1;
    wait_cycles(40);
    check("mid_no_more", 32'(bytes_q.size()), 32'd1);
    if (bytes_q.size() >= 1)
      check("mid_byte0", 32'(bytes_q[0]), 32'hEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
